// File: rtl/receiver_interface_pkg.sv
// ---------------------------------------------------------------------------
// Package : receiver_interface_pkg
// Shared types and helpers for the receive-side framing guard.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package receiver_interface_pkg;

  localparam int BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  length;
    logic [63:0] data;
  } beat_t;

  // Bytes carried by one beat: full width unless it is the closing beat.
  function automatic logic [3:0] beat_nbytes(input logic eop, input logic [2:0] length);
    return eop ? ({1'b0, length} + 4'd1) : 4'(BEAT_BYTES);
  endfunction

endpackage

`default_nettype wire

// File: rtl/receiver_interface_sat_counter.sv
// ---------------------------------------------------------------------------
// Module : receiver_interface_sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module receiver_interface_sat_counter #(
  parameter int W = 16
) (
  input  logic         inc,
  input  logic         clk_net,
  input  logic         rst_n,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/receiver_interface_framing_guard.sv
// ---------------------------------------------------------------------------
// Module : receiver_interface_framing_guard
// Sanitises the raw beat stream into well-formed, length-bounded packets.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module receiver_interface_framing_guard
  import receiver_interface_pkg::*;
#(
  parameter int MAX_PACKET_LEN = 1500,
  parameter int TIMEOUT_CYC    = 64,
  parameter int CNT_W          = 16,
  parameter int BC_W           = $clog2(MAX_PACKET_LEN + 1)
) (
  input  logic             clk_net,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [2:0]       in_length,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_length,
  output logic [63:0]      out_data,
  output logic             out_err,
  output logic [BC_W-1:0]  out_byte_count,
  output logic [CNT_W-1:0] good_pkt_cnt,
  output logic [CNT_W-1:0] err_pkt_cnt,
  output logic [CNT_W-1:0] drop_beat_cnt
);

  // Keep at least one spare bit above the byte-count width so bcnt+nb never wraps.
  localparam int BCNT_W = ((BC_W + 1) > 12) ? (BC_W + 1) : 12;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BCNT_W-1:0] c_max_len    = BCNT_W'(MAX_PACKET_LEN);
  localparam logic [BCNT_W-1:0] c_beat_bytes = BCNT_W'(BEAT_BYTES);
  localparam logic [IDLE_W-1:0] c_idle_last  = IDLE_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic [BCNT_W-1:0] r_bcnt;
  logic [IDLE_W-1:0] r_idle_cnt;

  logic              r_out_valid;
  beat_t             r_out;
  logic              r_out_err;
  logic [BC_W-1:0]   r_out_bc;

  beat_t             w_in_beat;
  logic [BCNT_W-1:0] w_nb;
  logic [BCNT_W-1:0] w_total;
  logic              w_over;
  logic              w_idle_expire;
  logic [2:0]        w_trunc_len;
  logic              w_good_inc;
  logic              w_err_inc;
  logic              w_drop_inc;

  assign w_in_beat     = '{sop: in_sop, eop: in_eop, length: in_length, data: in_data};
  assign w_nb          = BCNT_W'(beat_nbytes(in_eop, in_length));
  assign w_total       = r_bcnt + w_nb;
  // Landing exactly on the limit is only legal when this beat closes the packet.
  assign w_over        = (w_total > c_max_len) || ((w_total == c_max_len) && !in_eop);
  assign w_idle_expire = (r_idle_cnt == c_idle_last);
  assign w_trunc_len   = 3'(c_max_len - r_bcnt - BCNT_W'(1));

  always_comb begin
    w_good_inc = 1'b0;
    w_err_inc  = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_sop && in_eop) w_good_inc = 1'b1;
        if (in_valid && !in_sop)          w_drop_inc = 1'b1;
      end
      IN_PKT: begin
        if (in_valid) begin
          if (in_sop) begin
            w_err_inc  = 1'b1;
            w_drop_inc = 1'b1;
          end else if (w_over) begin
            w_err_inc  = 1'b1;
          end else if (in_eop) begin
            w_good_inc = 1'b1;
          end
        end else if (w_idle_expire) begin
          w_err_inc = 1'b1;
        end
      end
      DISCARD: begin
        if (in_valid) w_drop_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bcnt      <= '0;
      r_idle_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_err   <= 1'b0;
      r_out_bc    <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_err   <= 1'b0;
      r_out_bc    <= '0;
      case (r_state)
        IDLE: begin
          if (in_valid && in_sop) begin
            r_out_valid <= 1'b1;
            r_out       <= w_in_beat;
            r_out_bc    <= BC_W'(w_nb);
            if (!in_eop) begin
              r_state    <= IN_PKT;
              r_bcnt     <= c_beat_bytes;
              r_idle_cnt <= '0;
            end
          end
        end
        IN_PKT: begin
          if (in_valid) begin
            r_idle_cnt <= '0;
            if (in_sop) begin
              // Synthetic close: zero pad byte, counted in the reported length.
              r_out_valid <= 1'b1;
              r_out.eop   <= 1'b1;
              r_out_err   <= 1'b1;
              r_out_bc    <= BC_W'(r_bcnt + BCNT_W'(1));
              r_state     <= in_eop ? IDLE : DISCARD;
            end else if (w_over) begin
              r_out_valid  <= 1'b1;
              r_out.data   <= in_data;
              r_out.eop    <= 1'b1;
              r_out.length <= w_trunc_len;
              r_out_err    <= 1'b1;
              r_out_bc     <= BC_W'(c_max_len);
              r_state      <= in_eop ? IDLE : DISCARD;
            end else begin
              r_out_valid <= 1'b1;
              r_out       <= w_in_beat;
              r_out_bc    <= BC_W'(w_total);
              if (in_eop) r_state <= IDLE;
              else        r_bcnt  <= w_total;
            end
          end else if (w_idle_expire) begin
            r_out_valid <= 1'b1;
            r_out.eop   <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_bc    <= BC_W'(r_bcnt + BCNT_W'(1));
            r_idle_cnt  <= '0;
            r_state     <= IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end
        DISCARD: begin
          if (in_valid && in_eop) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_sop        = r_out.sop;
  assign out_eop        = r_out.eop;
  assign out_length     = r_out.length;
  assign out_data       = r_out.data;
  assign out_err        = r_out_err;
  assign out_byte_count = r_out_bc;

  receiver_interface_sat_counter #(.W(CNT_W)) u_good_cnt (
    .inc     (w_good_inc),
    .clk_net (clk_net),
    .rst_n   (rst_n),
    .count   (good_pkt_cnt)
  );

  receiver_interface_sat_counter #(.W(CNT_W)) u_err_cnt (
    .inc     (w_err_inc),
    .clk_net (clk_net),
    .rst_n   (rst_n),
    .count   (err_pkt_cnt)
  );

  receiver_interface_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .inc     (w_drop_inc),
    .clk_net (clk_net),
    .rst_n   (rst_n),
    .count   (drop_beat_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_receiver_interface_framing_guard.sv
// ---------------------------------------------------------------------------
// Testbench : tb_receiver_interface_framing_guard
// Directed framing cases plus random traffic against a packet-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_receiver_interface_framing_guard;

  localparam int MAX = 1500;
  localparam int TMO = 64;
  localparam int CW  = 16;
  localparam int SW  = 2;

  logic        clk_net = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]  in_length = '0;
  logic [63:0] in_data = '0;

  logic        out_valid, out_sop, out_eop, out_err;
  logic [2:0]  out_length;
  logic [63:0] out_data;
  logic [10:0] out_byte_count;
  logic [CW-1:0] good_pkt_cnt, err_pkt_cnt, drop_beat_cnt;

  logic        s_valid, s_sop, s_eop, s_err;
  logic [2:0]  s_length;
  logic [63:0] s_data;
  logic [10:0] s_byte_count;
  logic [SW-1:0] s_good, s_bad, s_drop;

  always #5 clk_net = ~clk_net;

  receiver_interface_framing_guard #(.MAX_PACKET_LEN(MAX), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk_net(clk_net), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_length(in_length), .in_data(in_data),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_length(out_length),
    .out_data(out_data), .out_err(out_err), .out_byte_count(out_byte_count),
    .good_pkt_cnt(good_pkt_cnt), .err_pkt_cnt(err_pkt_cnt), .drop_beat_cnt(drop_beat_cnt)
  );

  // Narrow-counter copy on the same stream to exercise saturation.
  receiver_interface_framing_guard #(.MAX_PACKET_LEN(MAX), .TIMEOUT_CYC(TMO), .CNT_W(SW)) dut_sat (
    .clk_net(clk_net), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_length(in_length), .in_data(in_data),
    .out_valid(s_valid), .out_sop(s_sop), .out_eop(s_eop), .out_length(s_length),
    .out_data(s_data), .out_err(s_err), .out_byte_count(s_byte_count),
    .good_pkt_cnt(s_good), .err_pkt_cnt(s_bad), .drop_beat_cnt(s_drop)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: 0 = between packets, 1 = inside packet, 2 = discarding remainder.
  int m_mode = 0, m_bytes = 0, m_idle = 0, m_good = 0, m_bad = 0, m_drop = 0;
  bit e_valid, e_sop, e_eop, e_err;
  logic [2:0]  e_len;
  logic [63:0] e_data;
  int e_bc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x, input int w);
    int lim = (1 << w) - 1;
    return (x > lim) ? lim : x;
  endfunction

  task automatic emit_synthetic();
    e_valid = 1; e_eop = 1; e_err = 1; e_bc = m_bytes + 1;
    m_bad++;
  endtask

  task automatic model_step();
    int nb, total;
    e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_len = '0; e_data = '0; e_bc = 0;
    if (!rst_n) begin
      m_mode = 0; m_bytes = 0; m_idle = 0; m_good = 0; m_bad = 0; m_drop = 0;
      return;
    end
    nb    = in_eop ? int'(in_length) + 1 : 8;
    total = m_bytes + nb;
    if (m_mode == 0) begin
      if (in_valid && in_sop) begin
        e_valid = 1; e_sop = 1; e_eop = in_eop; e_len = in_length; e_data = in_data; e_bc = nb;
        if (in_eop) m_good++;
        else begin m_mode = 1; m_bytes = 8; m_idle = 0; end
      end else if (in_valid) m_drop++;
    end else if (m_mode == 1) begin
      if (in_valid) begin
        m_idle = 0;
        if (in_sop) begin
          emit_synthetic();
          m_drop++;
          m_mode = in_eop ? 0 : 2;
        end else if (total > MAX || (total == MAX && !in_eop)) begin
          e_valid = 1; e_eop = 1; e_err = 1; e_data = in_data;
          e_len = 3'(MAX - m_bytes - 1); e_bc = MAX;
          m_bad++;
          m_mode = in_eop ? 0 : 2;
        end else begin
          e_valid = 1; e_eop = in_eop; e_len = in_length; e_data = in_data; e_bc = total;
          if (in_eop) begin m_good++; m_mode = 0; end
          else m_bytes = total;
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          emit_synthetic();
          m_mode = 0;
        end
      end
    end else begin
      if (in_valid) begin
        m_drop++;
        if (in_eop) m_mode = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(e_valid));
    if (e_valid) begin
      check_eq("out_sop", 64'(out_sop), 64'(e_sop));
      check_eq("out_eop", 64'(out_eop), 64'(e_eop));
      check_eq("out_err", 64'(out_err), 64'(e_err));
      check_eq("out_data", out_data, e_data);
      if (e_eop) begin
        check_eq("out_length", 64'(out_length), 64'(e_len));
        check_eq("out_byte_count", 64'(out_byte_count), 64'(e_bc));
      end
    end
    check_eq("good_pkt_cnt", 64'(good_pkt_cnt), 64'(sat(m_good, CW)));
    check_eq("err_pkt_cnt", 64'(err_pkt_cnt), 64'(sat(m_bad, CW)));
    check_eq("drop_beat_cnt", 64'(drop_beat_cnt), 64'(sat(m_drop, CW)));
    check_eq("sat_good", 64'(s_good), 64'(sat(m_good, SW)));
    check_eq("sat_err", 64'(s_bad), 64'(sat(m_bad, SW)));
    check_eq("sat_drop", 64'(s_drop), 64'(sat(m_drop, SW)));
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit e,
                      input logic [2:0] l, input logic [63:0] d);
    rst_n = r; in_valid = v; in_sop = s; in_eop = e; in_length = l; in_data = d;
    @(posedge clk_net);
    model_step();
    #1;
    compare_outputs();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_cycle();
    step(1, 0, 1'($urandom), 1'($urandom), 3'($urandom), rnd64());
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_packet();
    int kind, nbeats, g, run;
    bit abort;
    kind = $urandom_range(0, 19);
    if (kind == 0) begin
      step(1, 1, 0, 1'($urandom), 3'($urandom), rnd64());
    end else begin
      nbeats = (kind == 1) ? $urandom_range(180, 200) : $urandom_range(1, 8);
      for (int i = 0; i < nbeats; i++) begin
        if (i > 0) begin
          g = $urandom_range(0, 30);
          run = (g == 0) ? $urandom_range(TMO - 2, TMO + 2) : (g < 5 ? $urandom_range(1, 3) : 0);
          for (int k = 0; k < run; k++) idle_cycle();
        end
        abort = (i > 0) && ($urandom_range(0, 39) == 0);
        step(1, 1, (i == 0) || abort, i == nbeats - 1, 3'($urandom), rnd64());
      end
    end
    for (int k = 0; k < $urandom_range(0, 2); k++) idle_cycle();
  endtask

  initial begin
    do_reset();
    check_eq("reset_valid", 64'(out_valid), 64'd0);
    check_eq("reset_drop", 64'(drop_beat_cnt), 64'd0);

    // Three-beat clean packet.
    step(1, 1, 1, 0, 3'd0, 64'h0706050403020100);
    step(1, 1, 0, 0, 3'd0, 64'h0f0e0d0c0b0a0908);
    step(1, 1, 0, 1, 3'd3, 64'h1716151413121110);
    check_eq("t1_bytes", 64'(out_byte_count), 64'd20);
    check_eq("t1_good", 64'(good_pkt_cnt), 64'd1);

    // Orphan beat outside a packet.
    do_reset();
    step(1, 1, 0, 1, 3'd5, rnd64());
    check_eq("t2_valid", 64'(out_valid), 64'd0);
    check_eq("t2_drop", 64'(drop_beat_cnt), 64'd1);

    // Oversize packet truncated at the byte limit.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1, 1, i == 0, i == 199, 3'd7, rnd64());
      if (i == 187) begin
        check_eq("t3_eop", 64'(out_eop), 64'd1);
        check_eq("t3_len", 64'(out_length), 64'd3);
        check_eq("t3_bytes", 64'(out_byte_count), 64'd1500);
      end
    end
    check_eq("t3_drop", 64'(drop_beat_cnt), 64'd12);
    check_eq("t3_err", 64'(err_pkt_cnt), 64'd1);

    // SOP arriving mid-packet aborts it.
    do_reset();
    step(1, 1, 1, 0, 3'd0, rnd64());
    step(1, 1, 0, 0, 3'd0, rnd64());
    step(1, 1, 1, 0, 3'd0, rnd64());
    check_eq("t4_bytes", 64'(out_byte_count), 64'd17);
    check_eq("t4_data", out_data, 64'd0);
    step(1, 1, 0, 0, 3'd0, rnd64());
    step(1, 1, 1, 1, 3'd2, rnd64());
    check_eq("t4_drop", 64'(drop_beat_cnt), 64'd3);

    // Idle timeout, then the beat-on-expiry variant.
    do_reset();
    step(1, 1, 1, 0, 3'd0, rnd64());
    for (int k = 0; k < TMO; k++) idle_cycle();
    check_eq("t5_err", 64'(out_err), 64'd1);
    check_eq("t5_bytes", 64'(out_byte_count), 64'd9);
    step(1, 1, 1, 0, 3'd0, rnd64());
    for (int k = 0; k < TMO - 1; k++) idle_cycle();
    step(1, 1, 0, 1, 3'd7, rnd64());
    check_eq("t5b_err", 64'(out_err), 64'd0);
    check_eq("t5b_bytes", 64'(out_byte_count), 64'd16);

    // Reset mid-packet abandons it; later non-SOP beats are orphans.
    step(1, 1, 1, 0, 3'd0, rnd64());
    step(0, 1, 0, 0, 3'd0, rnd64());
    check_eq("t6_good", 64'(good_pkt_cnt), 64'd0);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 3'd0, rnd64());
    check_eq("t6_sat_drop", 64'(s_drop), 64'd3);

    // Random traffic.
    for (int p = 0; p < 400; p++) begin
      if ($urandom_range(0, 99) == 0) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), rnd64());
      rand_packet();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
